// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the memory stage.
//   Opcode constants for the data-memory instructions, the memory-stage FSM
//   state encoding and the full-word byte-enable pattern.
package cpu_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port (purely combinational).
//   i_opcode  : instruction opcode
//   i_store   : access is a store (MemWrite)
//   i_lane    : address bits [1:0]; lane 0 is bits 31:24 (big-endian)
//   i_wsrc    : store source data
//   i_rdata   : raw word returned by memory
//   o_byte_op : access is lb/lbu/sb (no alignment requirement)
//   o_be      : byte enables, [3] = byte at addr+0
//   o_wdata   : store data, byte replicated on all lanes for sb
//   o_load    : extracted and extended load result
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic        i_store,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wsrc,
    input  logic [31:0] i_rdata,
    output logic        o_byte_op,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);
    logic       w_sb;
    logic       w_lb;
    logic [7:0] w_byte;

    // Unknown opcodes fall through to the word forms.
    assign w_sb      = i_store & (i_opcode == OP_SB);
    assign w_lb      = ~i_store & ((i_opcode == OP_LB) | (i_opcode == OP_LBU));
    assign o_byte_op = w_sb | w_lb;

    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_wsrc;
        if (w_sb) begin
            o_be    = 4'b1000 >> i_lane;
            o_wdata = {4{i_wsrc[7:0]}};
        end
    end

    always_comb begin
        o_load = i_rdata;
        if (w_lb)
            o_load = (i_opcode == OP_LB) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the pipelined MIPS CPU.
//   Consumes EX/MEM fields (*_in), resolves branch/jump redirects, runs the
//   data-memory req/ack access (mem_*), stalls upstream while the access is
//   outstanding and drives the MEM/WB fields (*_out). mem_err pulses for one
//   cycle on a misaligned word access or when no ack arrives within
//   TIMEOUT_CYCLES request cycles.
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              Branch_in,
    input  logic              Jump_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              Zero_in,
    input  logic [5:0]        opcode_in,
    input  logic [DATA_W-1:0] CAL_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] branch_addr_in,
    input  logic [DATA_W-1:0] jump_addr_in,
    input  logic [4:0]        wn_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              mem_err,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic [DATA_W-1:0] CAL_out,
    output logic [4:0]        wn_out
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t         r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_access, w_misalign, w_byte_op, w_limit;
    logic               w_issue, w_err, w_capture, w_abort, w_count, w_latch;
    logic [3:0]         w_be;
    logic [DATA_W-1:0]  w_wdata, w_load;

    mem_lane_align u_align (
        .i_opcode  (opcode_in),
        .i_store   (MemWrite_in),
        .i_lane    (CAL_in[1:0]),
        .i_wsrc    (rd2_in),
        .i_rdata   (mem_rdata),
        .o_byte_op (w_byte_op),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_load    (w_load)
    );

    assign w_access   = MemRead_in | MemWrite_in;
    assign w_misalign = ~w_byte_op & (CAL_in[1:0] != 2'b00);
    assign w_limit    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign pc_redirect = (Jump_in | (Branch_in & Zero_in)) & ~stall;
    assign pc_target   = Jump_in ? jump_addr_in : branch_addr_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        w_issue   = 1'b0;
        w_err     = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        w_count   = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    stall = 1'b1;
                    if (w_misalign) begin
                        w_err  = 1'b1;
                        w_next = ST_DONE;
                    end else begin
                        w_issue = 1'b1;
                        w_next  = ST_REQ;
                    end
                end else begin
                    w_latch = 1'b1;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                // An ack arriving on the limit cycle still completes the access.
                if (mem_ack) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end else if (w_limit) begin
                    w_abort = 1'b1;
                    w_err   = 1'b1;
                    w_next  = ST_DONE;
                end else begin
                    w_count = 1'b1;
                end
            end
            ST_DONE: begin
                // EX/MEM advances on this edge, so IDLE sees the next instruction.
                w_latch = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'h0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_err      <= 1'b0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            rdata_out    <= '0;
            CAL_out      <= '0;
            wn_out       <= '0;
        end else begin
            mem_err <= w_err;
            if (w_issue) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite_in;
                mem_be    <= w_be;
                mem_addr  <= {CAL_in[DATA_W-1:2], 2'b00};
                mem_wdata <= w_wdata;
                r_cnt     <= '0;
            end
            if (w_capture) begin
                mem_req <= 1'b0;
                r_rdata <= w_load;
            end
            if (w_abort) begin
                mem_req <= 1'b0;
                r_rdata <= '0;
            end
            if (w_err && r_state == ST_IDLE)
                r_rdata <= '0;
            if (w_count)
                r_cnt <= r_cnt + CNT_W'(1);

            // Stalled cycles send a bubble; data fields just hold.
            if (w_latch) begin
                RegWrite_out <= RegWrite_in;
                MemtoReg_out <= MemtoReg_in;
                CAL_out      <= CAL_in;
                wn_out       <= wn_in;
                rdata_out    <= (r_state == ST_DONE) ? r_rdata : '0;
            end else begin
                RegWrite_out <= 1'b0;
                MemtoReg_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        MemRead_in = 0, MemWrite_in = 0, Branch_in = 0, Jump_in = 0;
    logic        RegWrite_in = 0, MemtoReg_in = 0, Zero_in = 0;
    logic [5:0]  opcode_in = 0;
    logic [31:0] CAL_in = 0, rd2_in = 0, branch_addr_in = 0, jump_addr_in = 0;
    logic [4:0]  wn_in = 0;
    logic        mem_req, mem_we, stall, pc_redirect, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, pc_target;
    logic [31:0] mem_rdata = 0;
    logic        mem_ack = 0;
    logic        RegWrite_out, MemtoReg_out;
    logic [31:0] rdata_out, CAL_out;
    logic [4:0]  wn_out;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(16), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
        .Jump_in(Jump_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .Zero_in(Zero_in), .opcode_in(opcode_in), .CAL_in(CAL_in), .rd2_in(rd2_in),
        .branch_addr_in(branch_addr_in), .jump_addr_in(jump_addr_in), .wn_in(wn_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .mem_err(mem_err), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .rdata_out(rdata_out), .CAL_out(CAL_out), .wn_out(wn_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] cal;
        logic [4:0]  wn;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    int n_stall, n_req, n_err;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one EX/MEM instruction at a negedge and push its MEM/WB expectation.
    task automatic drive(input logic mr, input logic mw, input logic br, input logic jp,
                         input logic rw, input logic m2r, input logic z, input logic [5:0] op,
                         input logic [31:0] cal, input logic [31:0] rd2, input logic [4:0] wn,
                         input logic [31:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        MemRead_in = mr; MemWrite_in = mw; Branch_in = br; Jump_in = jp;
        RegWrite_in = rw; MemtoReg_in = m2r; Zero_in = z; opcode_in = op;
        CAL_in = cal; rd2_in = rd2; wn_in = wn;
        e.rw = rw; e.m2r = m2r; e.rdata = exp_rdata; e.cal = cal; e.wn = wn;
        q.push_back(e);
    endtask

    // Step the instruction to retirement acting as memory; ack on REQ cycle ack_at (0 = never).
    task automatic run(input int ack_at, input logic [31:0] rd);
        logic cur_stall;
        logic done = 0;
        n_stall = 0; n_req = 0; n_err = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    cap_we = mem_we; cap_be = mem_be; cap_addr = mem_addr; cap_wdata = mem_wdata;
                end
                mem_ack   = (n_req == ack_at);
                mem_rdata = mem_ack ? rd : 32'h0;
            end else begin
                mem_ack = 0;
            end
            cur_stall = stall;
            if (stall) n_stall++;
            @(posedge clk); #1;
            mem_ack = 0;
            if (mem_err) n_err++;
            if (!cur_stall) begin done = 1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $error("FAIL retire_budget observed=not_retired expected=retired");
        end
    endtask

    // MEM/WB outputs after the retiring edge against the scoreboard head.
    task automatic check_wb(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_rw"},    32'(RegWrite_out), 32'(e.rw));
            chk({tag, "_m2r"},   32'(MemtoReg_out), 32'(e.m2r));
            chk({tag, "_rdata"}, rdata_out, e.rdata);
            chk({tag, "_cal"},   CAL_out, e.cal);
            chk({tag, "_wn"},    32'(wn_out), 32'(e.wn));
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rw", 32'(RegWrite_out), 0);
        chk("rst_err", 32'(mem_err), 0);
        rst_n = 1;

        // lw, ack on first REQ cycle
        drive(1, 0, 0, 0, 1, 1, 0, 6'h23, 32'h100, 0, 5'd8, 32'hDEADBEEF);
        run(1, 32'hDEADBEEF);
        chk("lw_stall", n_stall, 2);
        chk("lw_req", n_req, 1);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", 32'(cap_be), 32'hF);
        chk("lw_we", 32'(cap_we), 0);
        chk("lw_err", n_err, 0);
        check_wb("lw");

        // lb / lbu at lane 3
        drive(1, 0, 0, 0, 1, 1, 0, 6'h20, 32'h103, 0, 5'd9, 32'hFFFFFFF0);
        run(1, 32'h112233F0);
        check_wb("lb");
        drive(1, 0, 0, 0, 1, 1, 0, 6'h24, 32'h103, 0, 5'd10, 32'h000000F0);
        run(2, 32'h112233F0);
        chk("lbu_req", n_req, 2);
        check_wb("lbu");

        // lb at lane 0, positive byte
        drive(1, 0, 0, 0, 1, 1, 0, 6'h20, 32'h204, 0, 5'd11, 32'h00000012);
        run(1, 32'h12345678);
        check_wb("lb0");

        // sb lane 1
        drive(0, 1, 0, 0, 0, 0, 0, 6'h28, 32'h101, 32'h000000AB, 5'd0, 32'h0);
        run(1, 32'h0);
        chk("sb_be", 32'(cap_be), 32'h4);
        chk("sb_wdata", cap_wdata, 32'hABABABAB);
        chk("sb_we", 32'(cap_we), 1);
        chk("sb_addr", cap_addr, 32'h100);
        check_wb("sb");

        // sw aligned
        drive(0, 1, 0, 0, 0, 0, 0, 6'h2B, 32'h208, 32'hCAFEF00D, 5'd0, 32'h0);
        run(1, 32'h0);
        chk("sw_be", 32'(cap_be), 32'hF);
        chk("sw_wdata", cap_wdata, 32'hCAFEF00D);
        check_wb("sw");

        // sw misaligned: no request, one error pulse
        drive(0, 1, 0, 0, 0, 0, 0, 6'h2B, 32'h102, 32'h1, 5'd0, 32'h0);
        run(1, 32'h0);
        chk("swmis_req", n_req, 0);
        chk("swmis_err", n_err, 1);
        chk("swmis_stall", n_stall, 1);
        check_wb("swmis");

        // lw misaligned with RegWrite set: error, rdata 0
        drive(1, 0, 0, 0, 1, 1, 0, 6'h23, 32'h101, 0, 5'd3, 32'h0);
        run(1, 32'h55555555);
        chk("lwmis_req", n_req, 0);
        chk("lwmis_err", n_err, 1);
        check_wb("lwmis");

        // Timeout: no ack
        drive(1, 0, 0, 0, 1, 1, 0, 6'h23, 32'h300, 0, 5'd4, 32'h0);
        run(0, 32'h0);
        chk("to_req", n_req, 16);
        chk("to_err", n_err, 1);
        chk("to_stall", n_stall, 17);
        check_wb("to");

        // Ack on the limit cycle wins
        drive(1, 0, 0, 0, 1, 1, 0, 6'h23, 32'h304, 0, 5'd5, 32'h0BADC0DE);
        run(16, 32'h0BADC0DE);
        chk("lim_req", n_req, 16);
        chk("lim_err", n_err, 0);
        check_wb("lim");

        // Branch taken, then jump priority
        drive(0, 0, 1, 0, 0, 0, 1, 6'h04, 32'h0, 0, 5'd0, 32'h0);
        branch_addr_in = 32'h40; jump_addr_in = 32'h800;
        #1;
        chk("beq_redir", 32'(pc_redirect), 1);
        chk("beq_target", pc_target, 32'h40);
        Jump_in = 1;
        #1;
        chk("jmp_redir", 32'(pc_redirect), 1);
        chk("jmp_target", pc_target, 32'h800);
        Zero_in = 0; Jump_in = 0;
        #1;
        chk("bnt_redir", 32'(pc_redirect), 0);
        run(1, 32'h0);
        chk("br_stall", n_stall, 0);
        check_wb("br");

        // ALU op with register write, no memory
        drive(0, 0, 0, 0, 1, 0, 0, 6'h00, 32'h12345678, 0, 5'd17, 32'h0);
        run(1, 32'h0);
        check_wb("alu");

        // Redirect suppressed while stalled
        drive(1, 0, 1, 0, 1, 1, 1, 6'h23, 32'h400, 0, 5'd6, 32'h0);
        #1;
        chk("stall_redir", 32'(pc_redirect), 0);
        chk("stall_comb", 32'(stall), 1);

        // Reset asserted during REQ
        @(posedge clk); #1;
        chk("rstreq_pre", 32'(mem_req), 1);
        #1 rst_n = 0;
        #1;
        chk("rstreq_req", 32'(mem_req), 0);
        void'(q.pop_back());
        @(negedge clk);
        MemRead_in = 0; Branch_in = 0; RegWrite_in = 0; MemtoReg_in = 0; Zero_in = 0;
        @(negedge clk);
        rst_n = 1;
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("late_ack_err", 32'(mem_err), 0);
        chk("late_ack_req", 32'(mem_req), 0);
        chk("late_ack_stall", 32'(stall), 0);
        chk("late_ack_rdata", rdata_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
